// File: rtl/ping_pong_monitor_pkg.sv
// Shared types and constants for the ping-pong counter monitor.
package ping_pong_monitor_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } mon_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_VALUE = 2'b01;
  localparam logic [1:0] ERR_DIR   = 2'b10;
  localparam logic [1:0] ERR_BOTH  = 2'b11;

  // Error cause encoding: direction mismatch in bit 1, value mismatch in bit 0.
  function automatic logic [1:0] err_code_f(input logic dir_mis, input logic val_mis);
    return {dir_mis, val_mis};
  endfunction

endpackage

// File: rtl/ping_pong_monitor_predictor.sv
// Reference model of the ping-pong counter: next out/dir from last cycle's sample.
module ping_pong_monitor_predictor
  import ping_pong_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] p_out,
  input  logic             p_dir,
  input  logic             p_en,
  input  logic             p_flip,
  input  logic [WIDTH-1:0] p_max,
  input  logic [WIDTH-1:0] p_min,
  input  logic             p_rst,
  output logic [WIDTH-1:0] exp_out_c,
  output logic             exp_dir_c
);

  logic frozen_c;
  logic step_c;

  // Counter refuses to move when out of range, bounds inverted, or pinned at a single value.
  always_comb begin
    frozen_c = (p_out > p_max) || (p_out < p_min) || (p_max < p_min) ||
               ((p_max == p_min) && (p_out == p_max));
    step_c   = p_dir ^ p_flip;
  end

  // Priority: reset, hold, bounce at max, bounce at min, free step.
  always_comb begin
    exp_out_c = p_out;
    exp_dir_c = p_dir;
    if (p_rst) begin
      exp_out_c = p_min;
      exp_dir_c = 1'b1;
    end else if (!p_en || frozen_c) begin
      exp_out_c = p_out;
      exp_dir_c = p_dir;
    end else if (p_out == p_max) begin
      exp_out_c = p_out - WIDTH'(1);
      exp_dir_c = 1'b0;
    end else if (p_out == p_min) begin
      exp_out_c = p_out + WIDTH'(1);
      exp_dir_c = 1'b1;
    end else begin
      exp_out_c = step_c ? (p_out + WIDTH'(1)) : (p_out - WIDTH'(1));
      exp_dir_c = step_c;
    end
  end

endmodule

// File: rtl/ping_pong_monitor.sv
// Receive-side checker for the ping-pong counter: predicts, compares, counts turnarounds.
module ping_pong_monitor
  import ping_pong_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             obs_rst,
  input  logic             obs_en,
  input  logic             obs_flip,
  input  logic [WIDTH-1:0] obs_max,
  input  logic [WIDTH-1:0] obs_min,
  input  logic [WIDTH-1:0] obs_out,
  input  logic             obs_dir,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] bounce_cnt
);

  mon_state_e       state;

  logic [WIDTH-1:0] p_out;
  logic             p_dir;
  logic             p_en;
  logic             p_flip;
  logic [WIDTH-1:0] p_max;
  logic [WIDTH-1:0] p_min;
  logic             p_rst;

  logic [WIDTH-1:0] exp_out_c;
  logic             exp_dir_c;
  logic             val_mis_c;
  logic             dir_mis_c;
  logic             bounce_c;

  ping_pong_monitor_predictor #(
    .WIDTH (WIDTH)
  ) u_predictor (
    .p_out     (p_out),
    .p_dir     (p_dir),
    .p_en      (p_en),
    .p_flip    (p_flip),
    .p_max     (p_max),
    .p_min     (p_min),
    .p_rst     (p_rst),
    .exp_out_c (exp_out_c),
    .exp_dir_c (exp_dir_c)
  );

  // Compare current sample against prediction; flag direction changes outside reset.
  always_comb begin
    val_mis_c = (obs_out != exp_out_c);
    dir_mis_c = (obs_dir != exp_dir_c);
    bounce_c  = (state != ST_UNLOCKED) && !obs_rst && !p_rst && (obs_dir != p_dir);
  end

  // History of the previous cycle's counter sample and controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_out  <= '0;
      p_dir  <= 1'b0;
      p_en   <= 1'b0;
      p_flip <= 1'b0;
      p_max  <= '0;
      p_min  <= '0;
      p_rst  <= 1'b0;
    end else begin
      p_out  <= obs_out;
      p_dir  <= obs_dir;
      p_en   <= obs_en;
      p_flip <= obs_flip;
      p_max  <= obs_max;
      p_min  <= obs_min;
      p_rst  <= obs_rst;
    end
  end

  // Lock/compare/fault state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_UNLOCKED;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        ST_UNLOCKED: begin
          state  <= ST_LOCKED;
          locked <= 1'b1;
        end
        ST_LOCKED: begin
          // Samples taken while the counter is in reset carry no information.
          if (!obs_rst && (val_mis_c || dir_mis_c)) begin
            state    <= ST_FAULT;
            locked   <= 1'b0;
            err      <= 1'b1;
            err_code <= err_code_f(dir_mis_c, val_mis_c);
          end
        end
        ST_FAULT: begin
          if (err_clr) begin
            state    <= ST_UNLOCKED;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
          end
        end
        default: begin
          state    <= ST_UNLOCKED;
          locked   <= 1'b0;
          err      <= 1'b0;
          err_code <= ERR_NONE;
        end
      endcase
    end
  end

  // Saturating turnaround counter; survives err_clr, cleared only by monitor reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bounce_cnt <= '0;
    end else if (bounce_c && (bounce_cnt != {CNT_W{1'b1}})) begin
      bounce_cnt <= bounce_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ping_pong_monitor.sv
// Directed checks of ping_pong_monitor against hand-computed expectations.
module tb_ping_pong_monitor;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             obs_rst;
  logic             obs_en;
  logic             obs_flip;
  logic [WIDTH-1:0] obs_max;
  logic [WIDTH-1:0] obs_min;
  logic [WIDTH-1:0] obs_out;
  logic             obs_dir;
  logic             err_clr;

  logic             locked;
  logic             err;
  logic [1:0]       err_code;
  logic [7:0]       bounce_cnt;

  logic             locked_s;
  logic             err_s;
  logic [1:0]       err_code_s;
  logic [1:0]       bounce_cnt_s;

  int n_chk  = 0;
  int n_pass = 0;

  ping_pong_monitor #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .obs_rst    (obs_rst),
    .obs_en     (obs_en),
    .obs_flip   (obs_flip),
    .obs_max    (obs_max),
    .obs_min    (obs_min),
    .obs_out    (obs_out),
    .obs_dir    (obs_dir),
    .err_clr    (err_clr),
    .locked     (locked),
    .err        (err),
    .err_code   (err_code),
    .bounce_cnt (bounce_cnt)
  );

  ping_pong_monitor #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .obs_rst    (obs_rst),
    .obs_en     (obs_en),
    .obs_flip   (obs_flip),
    .obs_max    (obs_max),
    .obs_min    (obs_min),
    .obs_out    (obs_out),
    .obs_dir    (obs_dir),
    .err_clr    (err_clr),
    .locked     (locked_s),
    .err        (err_s),
    .err_code   (err_code_s),
    .bounce_cnt (bounce_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Present one counter sample, let the monitor take it, then settle past the edge.
  task automatic step(input logic [WIDTH-1:0] o, input logic d);
    obs_out = o;
    obs_dir = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; obs_rst = 1'b0; obs_en = 1'b0; obs_flip = 1'b0;
    obs_max = '0; obs_min = '0; obs_out = '0; obs_dir = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_bounce", 32'(bounce_cnt), 32'd0);

    // Normal sweep min=2 max=5 starting from counter reset.
    rst = 1'b0; obs_en = 1'b1; obs_max = 4'd5; obs_min = 4'd2;
    obs_rst = 1'b1; step(4'd0, 1'b0); obs_rst = 1'b0;
    check("t1_locked_early", 32'(locked), 32'd1);
    step(4'd2, 1'b1); step(4'd3, 1'b1); step(4'd4, 1'b1); step(4'd5, 1'b1);
    step(4'd4, 1'b0);
    check("t1_bounce_top", 32'(bounce_cnt), 32'd1);
    step(4'd3, 1'b0); step(4'd2, 1'b0); step(4'd3, 1'b1);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_bounce", 32'(bounce_cnt), 32'd2);

    // Flip accepted, then flip with a wrong sample.
    obs_flip = 1'b1; step(4'd4, 1'b1); obs_flip = 1'b0;
    step(4'd3, 1'b0);
    check("t2_flip_ok", 32'(err), 32'd0);
    check("t2_bounce", 32'(bounce_cnt), 32'd3);
    step(4'd2, 1'b0); step(4'd3, 1'b1);
    obs_flip = 1'b1; step(4'd4, 1'b1); obs_flip = 1'b0;
    step(4'd5, 1'b1);
    check("t2_err", 32'(err), 32'd1);
    check("t2_code", 32'(err_code), 32'd3);
    check("t2_unlocked", 32'(locked), 32'd0);
    check("t2_bounce4", 32'(bounce_cnt), 32'd4);
    check("t2_sat_bounce", 32'(bounce_cnt_s), 32'd3);
    obs_rst = 1'b1; step(4'd0, 1'b0); obs_rst = 1'b0;
    check("t2_fault_kept", 32'(err), 32'd1);

    // err_clr from FAULT, relock, counter retained; err_clr in LOCKED is inert.
    err_clr = 1'b1; step(4'd2, 1'b1); err_clr = 1'b0;
    check("t5_clr_err", 32'(err), 32'd0);
    check("t5_clr_code", 32'(err_code), 32'd0);
    check("t5_clr_unlocked", 32'(locked), 32'd0);
    step(4'd3, 1'b1);
    check("t5_relock", 32'(locked), 32'd1);
    step(4'd4, 1'b1);
    check("t5_err_after", 32'(err), 32'd0);
    check("t5_bounce_kept", 32'(bounce_cnt), 32'd4);
    err_clr = 1'b1; step(4'd5, 1'b1); err_clr = 1'b0;
    check("t5_clr_locked", 32'(locked), 32'd1);
    rst = 1'b1; step(4'd0, 1'b0); rst = 1'b0;
    check("t5_rst_bounce", 32'(bounce_cnt), 32'd0);
    check("t5_rst_locked", 32'(locked), 32'd0);

    // Mismatch coinciding with err_clr while LOCKED still faults; rst beats err_clr.
    obs_rst = 1'b1; step(4'd0, 1'b0); obs_rst = 1'b0;
    err_clr = 1'b1; step(4'd3, 1'b1); err_clr = 1'b0;
    check("clr_race_err", 32'(err), 32'd1);
    check("clr_race_code", 32'(err_code), 32'd1);
    rst = 1'b1; err_clr = 1'b1; step(4'd3, 1'b1); rst = 1'b0; err_clr = 1'b0;
    check("rst_ovr_err", 32'(err), 32'd0);
    check("rst_ovr_code", 32'(err_code), 32'd0);
    check("rst_ovr_locked", 32'(locked), 32'd0);

    // Inverted bounds freeze the counter; a moving value is a value error.
    obs_max = 4'd3; obs_min = 4'd6;
    step(4'd4, 1'b1); step(4'd4, 1'b1); step(4'd4, 1'b1);
    check("t3_hold_ok", 32'(err), 32'd0);
    step(4'd5, 1'b1);
    check("t3_err", 32'(err), 32'd1);
    check("t3_code", 32'(err_code), 32'd1);

    // Pinned max=min=out holds; en=0 with a stepping value is a value error.
    err_clr = 1'b1; obs_max = 4'd7; obs_min = 4'd7; step(4'd7, 1'b1); err_clr = 1'b0;
    check("t4_clr", 32'(err), 32'd0);
    step(4'd7, 1'b1); step(4'd7, 1'b1); step(4'd7, 1'b1);
    check("t4_pinned_ok", 32'(err), 32'd0);
    check("t4_locked", 32'(locked), 32'd1);
    obs_en = 1'b0; step(4'd7, 1'b1); step(4'd6, 1'b1);
    check("t4_err", 32'(err), 32'd1);
    check("t4_code", 32'(err_code), 32'd1);
    step(4'd2, 1'b0);
    check("t4_code_held", 32'(err_code), 32'd1);
    obs_en = 1'b1;

    // Five turnarounds: wide counter reads 5, narrow counter saturates at 3.
    rst = 1'b1; step(4'd0, 1'b0); rst = 1'b0;
    obs_max = 4'd4; obs_min = 4'd2;
    obs_rst = 1'b1; step(4'd0, 1'b0); obs_rst = 1'b0;
    step(4'd2, 1'b1); step(4'd3, 1'b1); step(4'd4, 1'b1); step(4'd3, 1'b0);
    step(4'd2, 1'b0); step(4'd3, 1'b1); step(4'd4, 1'b1); step(4'd3, 1'b0);
    step(4'd2, 1'b0); step(4'd3, 1'b1); step(4'd4, 1'b1); step(4'd3, 1'b0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_bounce", 32'(bounce_cnt), 32'd5);
    check("t6_sat", 32'(bounce_cnt_s), 32'd3);

    // Counter reset mid-sweep: garbage ignored, next sample must be (min, up).
    obs_rst = 1'b1; step(4'd9, 1'b0); obs_rst = 1'b0;
    step(4'd2, 1'b1);
    check("t6_post_rst_ok", 32'(err), 32'd0);
    check("t6_post_rst_bounce", 32'(bounce_cnt), 32'd5);
    step(4'd3, 1'b1);
    obs_rst = 1'b1; step(4'd4, 1'b1); obs_rst = 1'b0;
    step(4'd3, 1'b0);
    check("t6_post_rst_err", 32'(err), 32'd1);
    check("t6_post_rst_code", 32'(err_code), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
